ir_block_fetcher: RTL and testbench
===================================

Name: ir_block_fetcher

Overview:
- Supplier side of the IR-block load protocol used by the IR controller.
- On a block-load request with a base address, it reads BLOCK_LEN consecutive instruction words from instruction memory.
- Memory has a fixed 1-cycle read latency. Words are streamed to the controller over a valid/ready handshake through a 2-entry output FIFO, so backpressure never drops data.
- Sits between instruction memory and the IR controller's block loader. Supports flush on jump.

Parameters:
- IR_WIDTH, 8, instruction word width.
- ADDR_WIDTH, 8, instruction memory address width.
- BLOCK_LEN, 8, words per IR block (power of 2, at least 2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- i_req  in  1  block-load request, sampled only in IDLE.
- i_addr  in  ADDR_WIDTH  block base address, captured with i_req.
- i_flush  in  1  abort the current block; return to IDLE.
- o_mem_rd  out  1  memory read strobe.
- o_mem_addr  out  ADDR_WIDTH  memory read address.
- i_mem_data  in  IR_WIDTH  read data, valid in the cycle after o_mem_rd.
- o_ir  out  IR_WIDTH  FIFO head instruction.
- o_ir_valid  out  1  o_ir is valid.
- i_ir_ready  in  1  consumer accepts o_ir this cycle.
- o_busy  out  1  high while not IDLE.
- o_block_done  out  1  one-cycle pulse after the last word of a block is accepted.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state goes to IDLE; FIFO is emptied; counters and address are cleared.
  - o_mem_rd=0, o_mem_addr=0, o_ir_valid=0, o_ir=0, o_busy=0, o_block_done=0.
  - Reset mid-block discards any in-flight read data.
- States:
  - IDLE: on i_req=1, capture i_addr into rd_addr, clear issue_cnt and pop_cnt, go to FETCH.
  - FETCH: issue reads; when issue_cnt reaches BLOCK_LEN, go to DRAIN.
  - DRAIN: wait for the remaining words to be popped; on the last pop, pulse o_block_done and go to IDLE.
- Read issue:
  - In FETCH, o_mem_rd=1 iff issue_cnt<BLOCK_LEN and (fifo_count + inflight − pop) < 2, where pop = o_ir_valid & i_ir_ready.
  - o_mem_addr = rd_addr (combinational from the register). On each issue, rd_addr increments and wraps modulo 2^ADDR_WIDTH; issue_cnt increments.
  - inflight is a 1-bit register set by an issue. The next cycle i_mem_data is pushed into the FIFO.
- FIFO:
  - 2 entries; push and pop allowed in the same cycle.
  - The credit rule guarantees the FIFO never overflows.
  - o_ir and o_ir_valid come from registered FIFO state; o_ir=0 when empty.
- Latency and throughput:
  - i_req sampled at edge T0 → o_mem_rd high in cycle T0..T1 → word written at T2 → o_ir_valid high from T2.
  - With i_ir_ready held high: one word per cycle; o_block_done pulses the cycle after the BLOCK_LEN-th accept edge.
  - Request-to-done = BLOCK_LEN+2 cycles.
- o_busy = (state != IDLE).
- Simultaneous events:
  - i_req while busy is ignored and not queued.
  - i_flush has priority over everything except reset. It forces IDLE, empties the FIFO, drops inflight data, and suppresses o_block_done.
  - i_flush and i_req together in IDLE: flush wins and the request is dropped.
  - i_req in the cycle where DRAIN finishes is ignored; it is accepted only in IDLE.
- i_ir_ready while o_ir_valid=0 has no effect.
- o_ir must stay stable while o_ir_valid=1 and i_ir_ready=0.

Decomposition:
- Shared package/define file holds IR_WIDTH, ADDR_WIDTH, BLOCK_LEN defaults and the 3-bit one-hot state codes F_IDLE=3'b001, F_FETCH=3'b010, F_DRAIN=3'b100.
- The opcode constants (LOAD_IR_BLOCK, SET_DATA) already live there.
- One sub-module: ir_fifo2, a 2-entry synchronous FIFO with push, pop, data, count, empty and a flush clear.
- The credit logic, counters and FSM stay in the top level.

Test Plan:
- Basic block: reset, memory word at address a = 8'h10+a, i_req with i_addr=8'h20, ready always high → o_ir sequence 30..37 on consecutive cycles; first valid 2 cycles after req; o_block_done 1 cycle after accepting 37; o_busy low after.
- Backpressure: same as basic block, but i_ir_ready toggles 1,0,0,1,… → all 8 words in order, none lost or duplicated; o_ir stable while stalled; o_mem_rd never issued when the FIFO plus inflight would exceed 2.
- Wrap: i_addr=8'hFC → o_mem_addr sequence FC,FD,FE,FF,00,01,02,03.
- Flush mid-block: i_flush after the 3rd accept → o_ir_valid=0 next cycle, no o_block_done, late memory data discarded; a new i_req with i_addr=8'h40 then delivers 50..57 cleanly.
- Ignored request: second i_req (i_addr=8'h80) during FETCH → only the first block is delivered; no reads from 8'h80.
- Reset mid-block: rst_n=0 for 1 cycle during DRAIN → all outputs 0 at the next edge; the FIFO is empty afterwards.

Source files
------------

// File: rtl/ir_block_fetcher_pkg.sv
// Shared constants for the IR block fetcher: default sizes, FSM state codes,
// controller opcodes and a small sizing helper.
package ir_block_fetcher_pkg;

    localparam int DEF_IR_WIDTH   = 8;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_BLOCK_LEN  = 8;

    localparam logic [2:0] F_IDLE  = 3'b001;
    localparam logic [2:0] F_FETCH = 3'b010;
    localparam logic [2:0] F_DRAIN = 3'b100;

    typedef enum logic [3:0] {
        OP_NOP        = 4'h0,
        LOAD_IR_BLOCK = 4'h1,
        SET_DATA      = 4'h2
    } ir_opcode_e;

    // Width of a counter that must hold every value from 0 up to len inclusive.
    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/ir_block_fetcher_if.sv
// Request, memory and instruction-stream signals of the IR block fetcher.
// master = the fetcher itself, slave = the controller/memory side.
interface ir_block_fetcher_if
    import ir_block_fetcher_pkg::*;
#(
    parameter int IR_WIDTH   = DEF_IR_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_flush;

    logic                  o_mem_rd;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [IR_WIDTH-1:0]   i_mem_data;

    logic [IR_WIDTH-1:0]   o_ir;
    logic                  o_ir_valid;
    logic                  i_ir_ready;

    logic                  o_busy;
    logic                  o_block_done;

    modport master (
        input  i_req, i_addr, i_flush, i_mem_data, i_ir_ready,
        output o_mem_rd, o_mem_addr, o_ir, o_ir_valid, o_busy, o_block_done
    );

    modport slave (
        output i_req, i_addr, i_flush, i_mem_data, i_ir_ready,
        input  o_mem_rd, o_mem_addr, o_ir, o_ir_valid, o_busy, o_block_done
    );

endinterface

// File: rtl/ir_block_fetcher_fifo2.sv
// Two-entry synchronous FIFO with simultaneous push/pop and a flush clear.
// The head word reads as zero whenever the FIFO is empty.
module ir_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count,
    output logic             o_empty
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = i_pop && (count_q != 2'd0);
        do_push  = i_push && ((count_q != 2'd2) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        if (i_flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_empty = (count_q == 2'd0);
    assign o_count = count_q;
    assign o_data  = o_empty ? '0 : mem_q[rd_ptr_q];

    // Upstream credit accounting must never present a push to a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_flush && (count_q == 2'd2) && !i_pop));

endmodule

// File: rtl/ir_block_fetcher.sv
// Fetches BLOCK_LEN consecutive instruction words from 1-cycle-latency memory
// and streams them to the IR controller through a 2-entry credit-managed FIFO.
module ir_block_fetcher
    import ir_block_fetcher_pkg::*;
#(
    parameter int IR_WIDTH   = DEF_IR_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BLOCK_LEN  = DEF_BLOCK_LEN
) (
    input  logic               clk,
    input  logic               rst_n,
    ir_block_fetcher_if.master bus
);

    localparam int            CW     = cnt_width(BLOCK_LEN);
    localparam logic [CW-1:0] LEN_C  = CW'(BLOCK_LEN);
    localparam logic [CW-1:0] LAST_C = CW'(BLOCK_LEN - 1);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [CW-1:0]         issue_cnt_q, issue_cnt_d;
    logic [CW-1:0]         pop_cnt_q, pop_cnt_d;
    logic                  inflight_q, inflight_d;
    logic                  block_done_q, block_done_d;

    logic [IR_WIDTH-1:0]   fifo_data;
    logic [1:0]            fifo_count;
    logic                  fifo_empty;
    logic                  pop, push, issue;
    logic [2:0]            credit;

    ir_fifo2 #(
        .WIDTH (IR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (bus.i_flush),
        .i_push  (push),
        .i_data  (bus.i_mem_data),
        .i_pop   (pop),
        .o_data  (fifo_data),
        .o_count (fifo_count),
        .o_empty (fifo_empty)
    );

    always_comb begin
        pop  = !fifo_empty && bus.i_ir_ready;
        push = inflight_q && !bus.i_flush;
        // Words already owed to the FIFO after this cycle's pop; a new read
        // is only safe while that leaves room for its data next cycle.
        credit = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
        issue  = (state_q == F_FETCH) && !bus.i_flush
              && (issue_cnt_q < LEN_C) && (credit < 3'd2);

        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        issue_cnt_d  = issue_cnt_q;
        pop_cnt_d    = pop_cnt_q;
        inflight_d   = issue;
        block_done_d = 1'b0;

        if (issue) begin
            rd_addr_d   = rd_addr_q + ADDR_WIDTH'(1);
            issue_cnt_d = issue_cnt_q + CW'(1);
        end
        if (pop) begin
            pop_cnt_d = pop_cnt_q + CW'(1);
        end

        case (state_q)
            F_IDLE: begin
                if (bus.i_req && !bus.i_flush) begin
                    state_d     = F_FETCH;
                    rd_addr_d   = bus.i_addr;
                    issue_cnt_d = '0;
                    pop_cnt_d   = '0;
                end
            end
            F_FETCH: begin
                if (issue_cnt_d == LEN_C) begin
                    state_d = F_DRAIN;
                end
            end
            F_DRAIN: begin
                if (pop && (pop_cnt_q == LAST_C)) begin
                    state_d      = F_IDLE;
                    block_done_d = 1'b1;
                end
            end
            default: state_d = F_IDLE;
        endcase

        if (bus.i_flush) begin
            state_d      = F_IDLE;
            inflight_d   = 1'b0;
            block_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= F_IDLE;
            rd_addr_q    <= '0;
            issue_cnt_q  <= '0;
            pop_cnt_q    <= '0;
            inflight_q   <= 1'b0;
            block_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            issue_cnt_q  <= issue_cnt_d;
            pop_cnt_q    <= pop_cnt_d;
            inflight_q   <= inflight_d;
            block_done_q <= block_done_d;
        end
    end

    assign bus.o_mem_rd     = issue;
    assign bus.o_mem_addr   = rd_addr_q;
    assign bus.o_ir         = fifo_data;
    assign bus.o_ir_valid   = !fifo_empty;
    assign bus.o_busy       = (state_q != F_IDLE);
    assign bus.o_block_done = block_done_q;

    // A stalled head word must hold until it is taken or flushed away.
    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.o_ir_valid && !bus.i_ir_ready && !bus.i_flush)
        |=> (bus.o_ir_valid && $stable(bus.o_ir)));

endmodule

// File: tb/tb_ir_block_fetcher.sv
// Self-checking bench: memory model with 1-cycle read latency, per-scenario tasks,
// expected words derived from memory contents and the block base address.
module tb_ir_block_fetcher;
    import ir_block_fetcher_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int BL = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ir_block_fetcher_if #(.IR_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ir_block_fetcher #(.IR_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_LEN(BL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] mem [256];

    always @(posedge clk) begin
        if (bus.o_mem_rd) bus.i_mem_data <= mem[bus.o_mem_addr];
        else              bus.i_mem_data <= DW'($urandom);
    end

    int total = 0;
    int bad   = 0;
    int cyc, done_seen, done_cycle, first_valid_cycle;
    int credit_viol, stall_viol, zero_viol, outstanding;
    int ready_mode, inject_cycle;
    logic [AW-1:0] inject_addr;
    logic busy_at_done, prev_valid, prev_ready;
    logic [DW-1:0] prev_ir;
    logic [7:0] got_q[$];
    logic [7:0] addr_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] eaddr_q[$];

    function automatic int qdiff(input logic [7:0] a[$], input logic [7:0] b[$]);
        for (int i = 0; i < b.size(); i++) begin
            if (i >= a.size()) return i;
            if (a[i] !== b[i]) return i;
        end
        if (a.size() != b.size()) return b.size();
        return -1;
    endfunction

    function automatic logic [7:0] qat(input logic [7:0] q[$], input int i);
        if (i < 0 || i >= q.size()) return 8'hxx;
        return q[i];
    endfunction

    function automatic logic ready_for(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 3 == 0);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Reference: a block is BLOCK_LEN words read from consecutive wrapping addresses.
    task automatic build_exp(input logic [AW-1:0] base);
        exp_q   = {};
        eaddr_q = {};
        for (int i = 0; i < BL; i++) begin
            eaddr_q.push_back(AW'(int'(base) + i));
            exp_q.push_back(mem[AW'(int'(base) + i)]);
        end
    endtask

    task automatic clear_obs();
        cyc = 0; done_seen = 0; done_cycle = -1; first_valid_cycle = -1;
        credit_viol = 0; stall_viol = 0; zero_viol = 0; outstanding = 0;
        busy_at_done = 1'bx; prev_valid = 1'b0; prev_ready = 1'b0; prev_ir = '0;
        got_q = {}; addr_q = {};
    endtask

    // Observe one cycle (inputs already driven at the falling edge), then advance.
    task automatic tick();
        logic acc;
        #1;
        acc = bus.o_ir_valid && bus.i_ir_ready;
        if (bus.o_mem_rd) begin
            addr_q.push_back(bus.o_mem_addr);
            if (outstanding - int'(acc) + 1 > 2) credit_viol++;
        end
        if (acc) got_q.push_back(bus.o_ir);
        if (bus.o_ir_valid && first_valid_cycle < 0) first_valid_cycle = cyc;
        if (!bus.o_ir_valid && bus.o_ir !== '0) zero_viol++;
        if (prev_valid && !prev_ready && (bus.o_ir_valid !== 1'b1 || bus.o_ir !== prev_ir))
            stall_viol++;
        if (bus.o_block_done === 1'b1) begin
            done_seen++;
            if (done_cycle < 0) begin
                done_cycle   = cyc;
                busy_at_done = bus.o_busy;
            end
        end
        outstanding += int'(bus.o_mem_rd) - int'(acc);
        prev_valid = bus.o_ir_valid;
        prev_ready = bus.i_ir_ready;
        prev_ir    = bus.o_ir;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_block(input logic [AW-1:0] base, input int max_cycles);
        clear_obs();
        bus.i_req      = 1'b1;
        bus.i_addr     = base;
        bus.i_ir_ready = ready_for(ready_mode, cyc);
        tick();
        while (done_seen == 0 && cyc < max_cycles) begin
            bus.i_req      = (cyc == inject_cycle);
            bus.i_addr     = (cyc == inject_cycle) ? inject_addr : base;
            bus.i_ir_ready = ready_for(ready_mode, cyc);
            tick();
        end
        bus.i_req = 1'b0;
        $display("block base=%h words=%0d reads=%0d done_cycle=%0d", base, got_q.size(), addr_q.size(), done_cycle);
    endtask

    task automatic test_reset();
        bus.i_req = 1'b0; bus.i_addr = '0; bus.i_flush = 1'b0; bus.i_ir_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({bus.o_mem_rd, bus.o_mem_addr, bus.o_ir_valid, bus.o_ir, bus.o_busy, bus.o_block_done} !== 20'h0) begin
            bad++;
            $display("FAIL reset_outputs: got rd=%b addr=%h valid=%b ir=%h busy=%b done=%b want all 0",
                     bus.o_mem_rd, bus.o_mem_addr, bus.o_ir_valid, bus.o_ir, bus.o_busy, bus.o_block_done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int d;
        ready_mode = 0;
        run_block(8'h20, 40);
        tick(); tick();
        build_exp(8'h20);
        d = qdiff(got_q, exp_q);
        total++;
        if (d !== -1) begin bad++; $display("FAIL basic_seq: idx %0d got %h want %h", d, qat(got_q, d), qat(exp_q, d)); end
        total++;
        if (first_valid_cycle !== 3) begin bad++; $display("FAIL basic_first_valid: got %0d want 3", first_valid_cycle); end
        total++;
        if (done_cycle !== BL + 3) begin bad++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cycle, BL + 3); end
        total++;
        if (done_seen !== 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", done_seen); end
        total++;
        if (busy_at_done !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", busy_at_done); end
        total++;
        if (zero_viol !== 0) begin bad++; $display("FAIL basic_ir_zero_when_empty: got %0d want 0", zero_viol); end
    endtask

    task automatic test_backpressure();
        int d;
        ready_mode = 1;
        run_block(8'h20, 80);
        build_exp(8'h20);
        d = qdiff(got_q, exp_q);
        total++;
        if (d !== -1) begin bad++; $display("FAIL bp_seq: idx %0d got %h want %h", d, qat(got_q, d), qat(exp_q, d)); end
        total++;
        if (stall_viol !== 0) begin bad++; $display("FAIL bp_stable: got %0d changes want 0", stall_viol); end
        total++;
        if (credit_viol !== 0) begin bad++; $display("FAIL bp_credit: got %0d overissues want 0", credit_viol); end
        total++;
        if (addr_q.size() !== BL) begin bad++; $display("FAIL bp_reads: got %0d want %0d", addr_q.size(), BL); end
        total++;
        if (done_seen !== 1) begin bad++; $display("FAIL bp_done: got %0d want 1", done_seen); end
    endtask

    task automatic test_wrap();
        int d;
        ready_mode = 0;
        run_block(8'hFC, 40);
        build_exp(8'hFC);
        d = qdiff(addr_q, eaddr_q);
        total++;
        if (d !== -1) begin bad++; $display("FAIL wrap_addr: idx %0d got %h want %h", d, qat(addr_q, d), qat(eaddr_q, d)); end
        d = qdiff(got_q, exp_q);
        total++;
        if (d !== -1) begin bad++; $display("FAIL wrap_seq: idx %0d got %h want %h", d, qat(got_q, d), qat(exp_q, d)); end
    endtask

    task automatic test_flush();
        int d;
        logic [7:0] part_q[$];
        ready_mode = 0;
        clear_obs();
        bus.i_req = 1'b1; bus.i_addr = 8'h20; bus.i_ir_ready = 1'b1;
        tick();
        bus.i_req = 1'b0;
        while (got_q.size() < 3 && cyc < 30) tick();
        bus.i_flush = 1'b1; bus.i_ir_ready = 1'b0;
        tick();
        bus.i_flush = 1'b0;
        #1;
        total++;
        if (bus.o_ir_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", bus.o_ir_valid); end
        total++;
        if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", bus.o_busy); end
        build_exp(8'h20);
        part_q = exp_q[0:2];
        d = qdiff(got_q, part_q);
        total++;
        if (d !== -1) begin bad++; $display("FAIL flush_prefix: idx %0d got %h want %h", d, qat(got_q, d), qat(part_q, d)); end
        clear_obs();
        bus.i_ir_ready = 1'b1;
        repeat (6) tick();
        total++;
        if (first_valid_cycle !== -1) begin bad++; $display("FAIL flush_late_data: got valid at %0d want none", first_valid_cycle); end
        total++;
        if (done_seen !== 0) begin bad++; $display("FAIL flush_no_done: got %0d want 0", done_seen); end
        run_block(8'h40, 40);
        build_exp(8'h40);
        d = qdiff(got_q, exp_q);
        total++;
        if (d !== -1) begin bad++; $display("FAIL flush_next_seq: idx %0d got %h want %h", d, qat(got_q, d), qat(exp_q, d)); end
        total++;
        if (done_seen !== 1) begin bad++; $display("FAIL flush_next_done: got %0d want 1", done_seen); end
    endtask

    task automatic test_ignored_req();
        int d;
        ready_mode   = 0;
        inject_cycle = 2;
        inject_addr  = 8'h80;
        run_block(8'h20, 40);
        inject_cycle = -1;
        build_exp(8'h20);
        d = qdiff(addr_q, eaddr_q);
        total++;
        if (d !== -1) begin bad++; $display("FAIL ignored_addr: idx %0d got %h want %h", d, qat(addr_q, d), qat(eaddr_q, d)); end
        d = qdiff(got_q, exp_q);
        total++;
        if (d !== -1) begin bad++; $display("FAIL ignored_seq: idx %0d got %h want %h", d, qat(got_q, d), qat(exp_q, d)); end
        tick(); tick(); tick();
        total++;
        if ({bus.o_busy, bus.o_ir_valid} !== 2'b00) begin
            bad++; $display("FAIL ignored_idle: got busy=%b valid=%b want 0 0", bus.o_busy, bus.o_ir_valid);
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        bus.i_req = 1'b1; bus.i_addr = 8'h20; bus.i_ir_ready = 1'b1;
        tick();
        bus.i_req = 1'b0;
        while (addr_q.size() < BL && cyc < 30) tick();
        bus.i_ir_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        total++;
        if ({bus.o_mem_rd, bus.o_mem_addr, bus.o_ir_valid, bus.o_ir, bus.o_busy, bus.o_block_done} !== 20'h0) begin
            bad++;
            $display("FAIL midreset_outputs: got rd=%b addr=%h valid=%b ir=%h busy=%b done=%b want all 0",
                     bus.o_mem_rd, bus.o_mem_addr, bus.o_ir_valid, bus.o_ir, bus.o_busy, bus.o_block_done);
        end
        clear_obs();
        bus.i_ir_ready = 1'b1;
        repeat (6) tick();
        total++;
        if (first_valid_cycle !== -1 || done_seen !== 0) begin
            bad++; $display("FAIL midreset_empty: got valid_at=%0d done=%0d want -1 0", first_valid_cycle, done_seen);
        end
    endtask

    task automatic test_random();
        int d;
        logic [AW-1:0] base;
        for (int it = 0; it < 8; it++) begin
            for (int a = 0; a < 256; a++) mem[a] = DW'($urandom);
            base       = AW'($urandom);
            ready_mode = 2;
            if (it % 2 == 1) begin
                bus.i_req = 1'b1; bus.i_flush = 1'b1; bus.i_addr = base ^ 8'h55;
                tick();
                bus.i_req = 1'b0; bus.i_flush = 1'b0;
                #1;
                total++;
                if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL rand_flush_req: got busy=%b want 0", bus.o_busy); end
            end
            run_block(base, 200);
            build_exp(base);
            d = qdiff(got_q, exp_q);
            total++;
            if (d !== -1) begin bad++; $display("FAIL rand_seq[%0d]: idx %0d got %h want %h", it, d, qat(got_q, d), qat(exp_q, d)); end
            total++;
            if (done_seen !== 1 || busy_at_done !== 1'b0) begin
                bad++; $display("FAIL rand_done[%0d]: got done=%0d busy=%b want 1 0", it, done_seen, busy_at_done);
            end
            total++;
            if (credit_viol + stall_viol + zero_viol !== 0) begin
                bad++; $display("FAIL rand_rules[%0d]: got credit=%0d stall=%0d zero=%0d want 0 0 0",
                                it, credit_viol, stall_viol, zero_viol);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = DW'(a + 8'h10);
        inject_cycle = -1;
        inject_addr  = '0;
        ready_mode   = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_flush();
        test_ignored_req();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
